// File: rtl/result_piso_tx_pkg.sv
// Shared frame layout and FSM encoding for the result serial transmitter.
package result_piso_tx_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned RES_LSB  = 0;
  localparam int unsigned MUL_LSB  = 16;
  localparam int unsigned COUT_BIT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/result_piso_tx.sv
// Parallel-in/serial-out transmitter for voted ALU results: captures the
// result word on LOAD and shifts it out LSB-first with optional even parity.
module result_piso_tx
  import result_piso_tx_pkg::*;
#(
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned FRAME_W   = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] RES_IN,
  input  logic [14:0] MUL_IN,
  input  logic        COUT_IN,
  input  logic        BIT_EN,
  output logic        DATA_OUT,
  output logic        TX_VALID,
  output logic        TX_LAST,
  output logic        BUSY,
  output logic        TX_DONE,
  output logic        OVERRUN
);

  if (FRAME_W != result_piso_tx_pkg::FRAME_W) begin : g_frame_w_check
    $error("result_piso_tx: FRAME_W must be 32");
  end

  localparam logic [5:0] LAST_IDX = 6'(FRAME_W - 1);

  tx_state_t          state, state_nx;
  logic [FRAME_W-1:0] sreg, sreg_nx, payload;
  logic [5:0]         cnt, cnt_nx;
  logic               par, par_nx;
  logic               data_nx, valid_nx, last_nx, busy_nx, done_nx, ovr_nx;

  always_comb begin
    payload                   = '0;
    payload[RES_LSB +: 16]    = RES_IN;
    payload[MUL_LSB +: 15]    = MUL_IN;
    payload[COUT_BIT]         = COUT_IN;
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    par_nx   = par;
    done_nx  = 1'b0;
    ovr_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (LOAD) begin
          sreg_nx  = payload;
          par_nx   = ^payload;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        ovr_nx = LOAD;
        if (BIT_EN) begin
          if (cnt == LAST_IDX) begin
            state_nx = PARITY_EN ? PARITY : IDLE;
            done_nx  = !PARITY_EN;
          end else begin
            cnt_nx  = cnt + 6'd1;
            sreg_nx = {1'b0, sreg[FRAME_W-1:1]};
          end
        end
      end
      PARITY: begin
        ovr_nx = LOAD;
        if (BIT_EN) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered
    // while still presenting bit 0 in the cycle right after LOAD.
    busy_nx  = (state_nx != IDLE);
    valid_nx = (state_nx != IDLE);
    last_nx  = (state_nx == PARITY) ||
               (!PARITY_EN && state_nx == SHIFT && cnt_nx == LAST_IDX);
    unique case (state_nx)
      SHIFT:   data_nx = sreg_nx[0];
      PARITY:  data_nx = par_nx;
      default: data_nx = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      par      <= 1'b0;
      DATA_OUT <= 1'b0;
      TX_VALID <= 1'b0;
      TX_LAST  <= 1'b0;
      BUSY     <= 1'b0;
      TX_DONE  <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= state_nx;
      sreg     <= sreg_nx;
      cnt      <= cnt_nx;
      par      <= par_nx;
      DATA_OUT <= data_nx;
      TX_VALID <= valid_nx;
      TX_LAST  <= last_nx;
      BUSY     <= busy_nx;
      TX_DONE  <= done_nx;
      OVERRUN  <= ovr_nx;
    end
  end

endmodule
